// File: rtl/wb_burst_initiator_if.sv
// Wishbone bus bundle between the burst initiator and its slave.
// The master modport is the initiator side.
interface wb_burst_initiator_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADR_WIDTH  = 5
);
    logic                  strobe_o;
    logic                  we_o;
    logic [ADR_WIDTH-1:0]  adr_o;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic                  ack_i;
    logic                  error_i;
    logic [DATA_WIDTH-1:0] wb_data_i;

    modport master (
        output strobe_o,
        output we_o,
        output adr_o,
        output wb_data_o,
        input  ack_i,
        input  error_i,
        input  wb_data_i
    );

    modport slave (
        input  strobe_o,
        input  we_o,
        input  adr_o,
        input  wb_data_o,
        output ack_i,
        output error_i,
        output wb_data_i
    );
endinterface

// File: rtl/wb_burst_initiator.sv
// Wishbone burst initiator: turns host requests into strobed beats
// with a one-cycle gap, and reports OK / error / timeout per request.
module wb_burst_initiator #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADR_WIDTH      = 5,
    parameter int COUNT_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADR_WIDTH-1:0]   req_adr,
    input  logic [COUNT_WIDTH-1:0] req_count,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_data_pop,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   done,
    output logic [1:0]             status,
    output logic [COUNT_WIDTH:0]   beats_done,
    wb_burst_initiator_if.master   bus
);
    localparam int BW = COUNT_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_GAP,
        S_DONE
    } state_t;

    state_t state;
    state_t next;

    logic                  we_q;
    logic [ADR_WIDTH-1:0]  adr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BW-1:0]         beats_left;
    logic [BW-1:0]         acked;
    logic [TW-1:0]         timer;

    logic accept;
    logic take_ack;
    logic take_err;
    logic take_tmo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next     = state;
        accept   = 1'b0;
        take_ack = 1'b0;
        take_err = 1'b0;
        take_tmo = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    next   = S_STROBE;
                end
            end
            S_STROBE: begin
                // error beats ack, and ack beats the timeout
                if (bus.error_i) begin
                    take_err = 1'b1;
                    next     = S_DONE;
                end else if (bus.ack_i) begin
                    take_ack = 1'b1;
                    if (beats_left == BW'(1)) begin
                        next = S_DONE;
                    end else begin
                        next = S_GAP;
                    end
                end else if (timer == TMO_LAST) begin
                    take_tmo = 1'b1;
                    next     = S_DONE;
                end
            end
            S_GAP: begin
                next = S_STROBE;
            end
            S_DONE: begin
                next = S_IDLE;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            beats_left  <= '0;
            acked       <= '0;
            timer       <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            wr_data_pop <= 1'b0;
            status      <= ST_OK;
            beats_done  <= '0;
        end else begin
            rd_valid    <= 1'b0;
            wr_data_pop <= 1'b0;

            if (accept) begin
                we_q       <= req_we;
                adr_q      <= req_adr;
                wdata_q    <= wr_data;
                beats_left <= {1'b0, req_count} + BW'(1);
                acked      <= '0;
                timer      <= '0;
            end

            if (state == S_GAP) begin
                wdata_q <= wr_data;
                timer   <= '0;
            end

            if (state == S_STROBE) begin
                timer <= timer + TW'(1);
            end

            if (take_ack) begin
                beats_left <= beats_left - BW'(1);
                acked      <= acked + BW'(1);
                if (we_q) begin
                    wr_data_pop <= 1'b1;
                end else begin
                    rd_data  <= bus.wb_data_i;
                    rd_valid <= 1'b1;
                end
            end

            if (state == S_STROBE && next == S_DONE) begin
                beats_done <= take_ack ? acked + BW'(1) : acked;
                if (take_err) begin
                    status <= ST_ERR;
                end else if (take_tmo) begin
                    status <= ST_TMO;
                end else begin
                    status <= ST_OK;
                end
            end
        end
    end

    assign req_ready     = (state == S_IDLE);
    assign done          = (state == S_DONE);
    assign bus.strobe_o  = (state == S_STROBE);
    assign bus.we_o      = we_q;
    assign bus.adr_o     = adr_q;
    assign bus.wb_data_o = wdata_q;
endmodule
